// File: rtl/shift_595_receiver_if.sv
// ---------------------------------------------------------------------------
// shift_595_receiver_if
//   Three-wire 74HC595-style link (shift clock, serial data, latch strobe).
//   The driver side uses the master modport and the receiver uses slave.
//
//   SCLK : link shift clock; data is shifted in on its rising edge
//   DIO  : link serial data, MSB first
//   RCLK : link latch strobe; a rising edge transfers the frame
// ---------------------------------------------------------------------------
interface shift_595_receiver_if;
  logic SCLK;
  logic DIO;
  logic RCLK;

  modport master (output SCLK, output DIO, output RCLK);
  modport slave  (input  SCLK, input  DIO, input  RCLK);
endinterface

// File: rtl/shift_595_receiver.sv
// ---------------------------------------------------------------------------
// shift_595_receiver
//   Serial-to-parallel receiver for the 74HC595-style link. The link pins are
//   asynchronous to clk and are oversampled through synchronizer chains.
//   DIO is shifted in MSB-first on each SCLK rising edge. A WIDTH-bit frame
//   is moved to data_out on an RCLK rising edge. Frames with the wrong bit
//   count, latches with no open frame, and frames that stall for
//   TIMEOUT_CNT cycles are reported on frame_err.
//
//   clk        : system clock, all logic on its rising edge
//   rst_n      : asynchronous active-low reset
//   link       : SCLK / DIO / RCLK link pins (slave modport)
//   data_out   : last good frame, MSB = first bit received
//   data_valid : one-cycle pulse when data_out updates
//   frame_err  : one-cycle pulse on bad bit count, empty latch or timeout
//   busy       : high while a frame is open
// ---------------------------------------------------------------------------
module shift_595_receiver #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CNT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_595_receiver_if.slave  link,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH + 1) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CNT) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Synchronizer chains, stage 0 is closest to the pin.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] dio_sync_q,  dio_sync_d;
  logic [SYNC_STAGES-1:0] rclk_sync_q, rclk_sync_d;

  // Previous synced values for edge detection.
  logic sclk_prev_q, sclk_prev_d;
  logic rclk_prev_q, rclk_prev_d;

  // Registered edge pulses plus the DIO sample that belongs to the SCLK edge.
  logic sclk_edge_q, sclk_edge_d;
  logic rclk_edge_q, rclk_edge_d;
  logic dio_bit_q,   dio_bit_d;

  // Frame state.
  state_t            state_q,   state_d;
  logic [WIDTH-1:0]  sr_q,      sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]  timer_q,   timer_d;

  // Registered outputs.
  logic [WIDTH-1:0]  data_out_q,   data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_err_q,  frame_err_d;
  logic              busy_q,       busy_d;

  // Next-state logic for the synchronizers, edge detectors and frame FSM.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], link.SCLK};
    dio_sync_d  = {dio_sync_q[SYNC_STAGES-2:0],  link.DIO};
    rclk_sync_d = {rclk_sync_q[SYNC_STAGES-2:0], link.RCLK};

    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    rclk_prev_d = rclk_sync_q[SYNC_STAGES-1];

    // The edge is registered for timing; DIO is delayed by the same stage so
    // the bit shifted in is the one sampled alongside the SCLK rise.
    sclk_edge_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    rclk_edge_d = rclk_sync_q[SYNC_STAGES-1] & ~rclk_prev_q;
    dio_bit_d   = dio_sync_q[SYNC_STAGES-1];

    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    timer_d      = timer_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // Shift and count first, so a latch arriving in the same cycle sees the
    // updated frame.
    if (sclk_edge_q) begin
      sr_d    = {sr_q[WIDTH-2:0], dio_bit_q};
      timer_d = '0;
      state_d = RECV;
      if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (state_q == RECV) begin
      timer_d = timer_q + TMR_W'(1);
    end

    // A latch always closes the frame and takes priority over the timeout.
    // A latch with no open frame sees a count of zero and is an error.
    if (rclk_edge_q) begin
      if (state_d == RECV && bit_cnt_d == CNT_FULL) begin
        data_out_d   = sr_d;
        data_valid_d = 1'b1;
      end else begin
        frame_err_d  = 1'b1;
      end
      bit_cnt_d = '0;
      timer_d   = '0;
      state_d   = IDLE;
    end else if (state_q == RECV && !sclk_edge_q && timer_q == TMR_LAST) begin
      frame_err_d = 1'b1;
      bit_cnt_d   = '0;
      timer_d     = '0;
      state_d     = IDLE;
    end

    busy_d = (state_d == RECV);
  end

  // All state registers. Clock/latch chains reset high so a line that is
  // already high when reset releases does not look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= '1;
      dio_sync_q   <= '0;
      rclk_sync_q  <= '1;
      sclk_prev_q  <= 1'b1;
      rclk_prev_q  <= 1'b1;
      sclk_edge_q  <= 1'b0;
      rclk_edge_q  <= 1'b0;
      dio_bit_q    <= 1'b0;
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      timer_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      dio_sync_q   <= dio_sync_d;
      rclk_sync_q  <= rclk_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      rclk_prev_q  <= rclk_prev_d;
      sclk_edge_q  <= sclk_edge_d;
      rclk_edge_q  <= rclk_edge_d;
      dio_bit_q    <= dio_bit_d;
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      timer_q      <= timer_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_595_receiver.sv
// ---------------------------------------------------------------------------
// tb_shift_595_receiver
//   Self-checking bench for shift_595_receiver. A behavioural link driver
//   produces SCLK/DIO/RCLK waveforms; a monitor counts output pulses and the
//   expected frames come from a table and from a bit-queue reference model.
// ---------------------------------------------------------------------------
module tb_shift_595_receiver;

  localparam int WIDTH       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CNT = 1000;
  localparam int HALF        = 50;
  localparam int FAST_HALF   = 4;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int LB_FRAMES   = 200;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             busy;

  shift_595_receiver_if link_if ();

  shift_595_receiver #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CNT (TIMEOUT_CNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link       (link_if),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Comparison bookkeeping.
  int n_cmp = 0;
  int n_bad = 0;

  // Posedge counter used to time-stamp stimulus and observed pulses.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  int               valid_cnt = 0;
  int               err_cnt   = 0;
  int               both_cnt  = 0;
  int               last_valid_cyc = -1;
  int               last_err_cyc   = -1;
  logic             busy_prev = 1'b0;
  logic             busy_at_valid = 1'b0;
  logic             busy_before_valid = 1'b0;
  logic [WIDTH-1:0] rx_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc    = cyc;
        busy_at_valid     = busy;
        busy_before_valid = busy_prev;
        rx_q.push_back(data_out);
      end
      if (frame_err === 1'b1) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (data_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end
    busy_prev = busy;
  end

  // Stimulus timestamps filled by the driver tasks.
  int last_rise_cyc = 0;
  int rclk_cyc      = 0;

  typedef struct {
    logic [31:0]      bits;
    int               nbits;
    int               exp_valid;
    int               exp_err;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  // Reference-model state for the loopback run.
  logic             ref_bits[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] lb_word;
  logic [WIDTH-1:0] lb_exp;
  logic [WIDTH-1:0] simul_word;
  int v0, e0;

  function automatic vec_t mkVec(input logic [31:0] bits, input int nbits,
                                 input int ev, input int ee,
                                 input logic [WIDTH-1:0] ed);
    vec_t v;
    v.bits = bits; v.nbits = nbits; v.exp_valid = ev; v.exp_err = ee; v.exp_data = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts the low n bits of 'bits' MSB-first with half-period 'half'.
  task automatic shiftBits(input logic [31:0] bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      link_if.DIO = bits[i];
      clocks(half);
      link_if.SCLK  = 1'b1;
      last_rise_cyc = cyc;
      clocks(half);
      link_if.SCLK = 1'b0;
    end
  endtask

  task automatic latchFrame(input int half);
    clocks(half);
    link_if.RCLK = 1'b1;
    rclk_cyc     = cyc;
    clocks(1);
    link_if.RCLK = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] bits, input int n, input int half);
    shiftBits(bits, n, half);
    latchFrame(half);
  endtask

  initial begin
    #(95000 * 10);
    $display("[TB] FAIL watchdog: got no completion, expected finish within 95000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    link_if.SCLK = 1'b0;
    link_if.DIO  = 1'b0;
    link_if.RCLK = 1'b0;
    #1 rst_n = 1'b0;
    clocks(3);

    // Reset values.
    checkOutput("reset data_out",   32'(data_out),   32'h0);
    checkOutput("reset data_valid", 32'(data_valid), 32'h0);
    checkOutput("reset frame_err",  32'(frame_err),  32'h0);
    checkOutput("reset busy",       32'(busy),       32'h0);
    rst_n = 1'b1;
    clocks(5);

    // Directed frames: good, short, long, empty latch and data patterns.
    vecs.push_back(mkVec(32'h0000A5C3, 16, 1, 0, 16'hA5C3));
    vecs.push_back(mkVec(32'h00001234, 16, 1, 0, 16'h1234));
    vecs.push_back(mkVec(32'h0000091A, 15, 0, 1, 16'h1234));
    vecs.push_back(mkVec(32'h00012345, 17, 0, 1, 16'h1234));
    vecs.push_back(mkVec(32'h00000000,  0, 0, 1, 16'h1234));
    vecs.push_back(mkVec(32'h0000FFFF, 16, 1, 0, 16'hFFFF));
    vecs.push_back(mkVec(32'h00000000, 16, 1, 0, 16'h0000));
    vecs.push_back(mkVec(32'h00008001, 16, 1, 0, 16'h8001));

    for (int i = 0; i < vecs.size(); i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      applyStimulus(vecs[i].bits, vecs[i].nbits, HALF);
      clocks(LAT + 4);
      checkOutput($sformatf("vec%0d valid pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d err pulses", i),   32'(err_cnt - e0),   32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d data_out", i),     32'(data_out),       32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d busy", i),         32'(busy),           32'h0);
      if (vecs[i].exp_valid != 0) begin
        checkOutput($sformatf("vec%0d valid latency", i), 32'(last_valid_cyc), 32'(rclk_cyc + LAT));
        checkOutput($sformatf("vec%0d busy before valid", i), 32'(busy_before_valid), 32'h1);
        checkOutput($sformatf("vec%0d busy at valid", i),     32'(busy_at_valid),     32'h0);
      end else begin
        checkOutput($sformatf("vec%0d err latency", i), 32'(last_err_cyc), 32'(rclk_cyc + LAT));
      end
    end

    // Timeout: 8 bits then SCLK stays low.
    v0 = valid_cnt;
    e0 = err_cnt;
    shiftBits(32'h000000C7, 8, HALF);
    clocks(10);
    checkOutput("timeout busy open", 32'(busy), 32'h1);
    clocks(TIMEOUT_CNT + 20);
    checkOutput("timeout err pulses", 32'(err_cnt - e0), 32'h1);
    checkOutput("timeout err time",   32'(last_err_cyc), 32'(last_rise_cyc + LAT + TIMEOUT_CNT));
    checkOutput("timeout busy",       32'(busy),         32'h0);
    checkOutput("timeout valid",      32'(valid_cnt - v0), 32'h0);
    applyStimulus(32'h0000BEEF, 16, HALF);
    clocks(LAT + 4);
    checkOutput("after timeout data_out", 32'(data_out), 32'hBEEF);

    // Bit counter saturation: 80 bits must not wrap back to a good count.
    e0 = err_cnt;
    shiftBits(32'hFFFFFFFF, 32, HALF);
    shiftBits(32'hFFFFFFFF, 32, HALF);
    applyStimulus(32'h0000FFFF, 16, HALF);
    clocks(LAT + 4);
    checkOutput("overlong err pulses", 32'(err_cnt - e0), 32'h1);
    checkOutput("overlong data_out",   32'(data_out),     32'hBEEF);

    // Last SCLK rise and RCLK rise in the same cycle form a good frame.
    v0 = valid_cnt;
    e0 = err_cnt;
    simul_word = 16'h3C5A;
    shiftBits(32'(simul_word >> 1), WIDTH - 1, HALF);
    link_if.DIO = simul_word[0];
    clocks(HALF);
    link_if.SCLK = 1'b1;
    link_if.RCLK = 1'b1;
    rclk_cyc     = cyc;
    clocks(1);
    link_if.RCLK = 1'b0;
    clocks(HALF - 1);
    link_if.SCLK = 1'b0;
    clocks(10);
    checkOutput("simul valid pulses", 32'(valid_cnt - v0), 32'h1);
    checkOutput("simul err pulses",   32'(err_cnt - e0),   32'h0);
    checkOutput("simul data_out",     32'(data_out),       32'h3C5A);
    checkOutput("simul latency",      32'(last_valid_cyc), 32'(rclk_cyc + LAT));

    // Reset in the middle of a frame.
    e0 = err_cnt;
    shiftBits(32'h000001AB, 9, HALF);
    rst_n = 1'b0;
    clocks(1);
    checkOutput("midreset data_out",   32'(data_out),   32'h0);
    checkOutput("midreset data_valid", 32'(data_valid), 32'h0);
    checkOutput("midreset frame_err",  32'(frame_err),  32'h0);
    checkOutput("midreset busy",       32'(busy),       32'h0);
    clocks(2);
    rst_n = 1'b1;
    clocks(20);
    checkOutput("midreset no err", 32'(err_cnt - e0), 32'h0);
    v0 = valid_cnt;
    applyStimulus(32'h00000F0F, 16, HALF);
    clocks(LAT + 4);
    checkOutput("after reset valid",    32'(valid_cnt - v0), 32'h1);
    checkOutput("after reset data_out", 32'(data_out),       32'h0F0F);

    // Random loopback against the bit-queue model.
    rx_q.delete();
    exp_q.delete();
    e0 = err_cnt;
    for (int f = 0; f < LB_FRAMES; f++) begin
      lb_word = WIDTH'($urandom);
      for (int b = WIDTH - 1; b >= 0; b--) ref_bits.push_back(lb_word[b]);
      applyStimulus(32'(lb_word), WIDTH, FAST_HALF);
      if (ref_bits.size() == WIDTH) begin
        lb_exp = '0;
        for (int j = 0; j < ref_bits.size(); j++) lb_exp = {lb_exp[WIDTH-2:0], ref_bits[j]};
        exp_q.push_back(lb_exp);
      end
      ref_bits.delete();
    end
    clocks(LAT + 10);
    checkOutput("loopback frame count", 32'(rx_q.size()), 32'(exp_q.size()));
    checkOutput("loopback err pulses",  32'(err_cnt - e0), 32'h0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput($sformatf("loopback word %0d", i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end

    checkOutput("pulse exclusivity", 32'(both_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_595_receiver.md
# shift_595_receiver

Serial-to-parallel receiver for the 74HC595-style three-wire link (SCLK, DIO, RCLK) that our shift drivers emit. It samples the link with the system clock, shifts DIO in MSB-first on each SCLK rising edge, and transfers a complete WIDTH-bit frame to a parallel output on the RCLK rising edge. It sits on the far side of a board or FPGA-to-FPGA link, or in loopback benches against the driver. It also flags malformed or stalled frames.

## Interface
- WIDTH, 16: frame length in bits.
- SYNC_STAGES, 2: synchronizer depth on each link input, 2 or more.
- TIMEOUT_CNT, 1000: clk cycles without an SCLK rising edge, with a frame open, before the frame is dropped.

- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  link shift clock, asynchronous to clk.
- DIO  in  1  link serial data, asynchronous to clk.
- RCLK  in  1  link latch strobe, asynchronous to clk.
- data_out  out  WIDTH  last good frame, MSB = first bit received.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse on bad bit count or timeout.
- busy  out  1  high while a frame is open (state RECV).

## Operation
- **Synchronizers:** each of SCLK, DIO and RCLK passes through SYNC_STAGES flops.
  - The SCLK and RCLK chains reset to 1. The DIO chain resets to 0.
- **Edge detection:** one extra registered copy each of synced SCLK and RCLK.
  - Rising edge = synced value is 1 and the registered copy is 0. Falling edges are ignored.
  - Because the chains reset to 1, a line already high at reset release produces no edge.
- **Shift register:** WIDTH bits, sr.
  - On an SCLK edge: sr <= {sr[WIDTH-2:0], DIO_synced}.
- **Bit counter:** bit_cnt, width clog2(WIDTH+1)+1.
  - Increments on each SCLK edge and saturates at WIDTH+1.
- **Idle timer:** counter, width clog2(TIMEOUT_CNT)+1.
  - Clears on every SCLK edge and on entry to RECV. Otherwise increments while in RECV.
- **FSM states:**
  - IDLE (bit_cnt = 0, busy = 0) moves to RECV on an SCLK edge.
  - RECV on an RCLK edge:
    - If bit_cnt == WIDTH: data_out <= sr and data_valid pulses.
    - Otherwise: frame_err pulses and data_out holds.
    - In both cases bit_cnt clears and the FSM goes to IDLE.
  - RECV when the idle timer reaches TIMEOUT_CNT-1 with no SCLK edge that cycle: frame_err pulses, bit_cnt clears, go to IDLE.
  - IDLE on an RCLK edge: frame_err pulses (empty latch), data_out holds.
- **Simultaneous SCLK and RCLK edges in the same cycle:** the shift and count happen first. The RCLK check uses the updated bit_cnt and sr, so a WIDTH-th bit plus latch in one cycle is a good frame.
- **Simultaneous RCLK edge and timeout:** the RCLK handling wins; timeout is not flagged.
- **Pulse exclusivity:** data_valid and frame_err are never high together.
- **Reset mid-frame:**
  - All state clears immediately and asynchronously.
  - Partial bits are discarded with no error pulse.
  - The next frame is received normally.

## Timing
- **Reset values:** data_out = 0, data_valid = 0, frame_err = 0, busy = 0. Internally: FSM = IDLE, sr = 0, bit_cnt = 0, timer = 0.
- **Edge latency:** a pin transition first sampled high at clk edge k is detected as an edge at edge k+SYNC_STAGES.
  - The effects (shift, busy, data_out, data_valid, frame_err) are visible after edge k+SYNC_STAGES+1.
- **Pulse width:** data_valid and frame_err are high for exactly one clk cycle.
- **Link requirements:**
  - SCLK high and low phases each last at least SYNC_STAGES+1 clk periods.
  - DIO is stable from SYNC_STAGES+1 clk periods before the SCLK rise until 1 clk period after it.
  - RCLK rises at least SYNC_STAGES+1 clk periods after the last SCLK rise.
  - Our driver at HALF_CNT = 50 meets all of these.
- **Throughput:** back-to-back frames are accepted with no dead cycles beyond the link requirements above.

## Test plan
- **Good frame:** 16 SCLK pulses (50 clk high / 50 clk low) carrying 0xA5C3 MSB-first, then a 1-clk RCLK pulse.
  -> data_out = 0xA5C3 and data_valid pulses once, exactly 3 clk after RCLK is first sampled high.
  -> frame_err stays 0 and busy falls in the same cycle.
- **Short and long frames:** after a good 0x1234 frame, send 15 bits then RCLK, and separately 17 bits then RCLK.
  -> frame_err pulses once for each; data_out stays 0x1234 and data_valid stays 0.
- **Timeout:** send 8 bits, then hold SCLK low.
  -> frame_err pulses exactly TIMEOUT_CNT clk after the last detected SCLK edge and busy drops.
  -> A following 0xBEEF frame then gives data_out = 0xBEEF.
- **Empty latch:** an RCLK pulse with no bits sent.
  -> frame_err pulses and data_out is unchanged.
- **Reset mid-frame:** drive rst_n low for 3 clk after 9 bits.
  -> All outputs read 0 during reset and no frame_err pulse occurs.
  -> A following 0x0F0F frame gives data_out = 0x0F0F.
- **Loopback:** shift_74hc595 (HALF_CNT = 50, WIDTH = 16) drives this block with 200 random words.
  -> Every data_out matches the corresponding data_in and frame_err stays 0 throughout.
